// File: rtl/sdrc_wb_master.sv
// Wishbone B3 initiator: turns a command stream plus write/read data streams into
// single or incrementing-burst bus cycles, with a watchdog for unresponsive slaves.
module sdrc_wb_master #(
    parameter int APP_AW  = 26,
    parameter int dw      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,

    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [APP_AW-1:0] cmd_addr_i,
    input  logic [2:0]        cmd_len_i,
    input  logic [dw/8-1:0]   cmd_sel_i,

    input  logic              wdat_valid_i,
    output logic              wdat_ready_o,
    input  logic [dw-1:0]     wdat_i,

    output logic              rdat_valid_o,
    output logic [dw-1:0]     rdat_o,

    output logic              done_o,
    output logic              err_o,

    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [dw-1:0]     wb_dat_o,
    output logic [dw/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [dw-1:0]     wb_dat_i
);

    localparam int                SW        = dw / 8;
    localparam logic [APP_AW-1:0] ADDR_STEP = APP_AW'(SW);
    localparam logic [7:0]        WD_LAST   = 8'(TIMEOUT - 1);

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t            state_reg, state_next;
    logic              we_reg, we_next;
    logic [APP_AW-1:0] addr_reg, addr_next;
    logic [SW-1:0]     sel_reg, sel_next;
    logic [3:0]        beats_reg, beats_next;
    logic [3:0]        acked_reg, acked_next;
    logic [3:0]        fed_reg, fed_next;
    logic              full_reg, full_next;
    logic [dw-1:0]     wbuf_reg, wbuf_next;
    logic [7:0]        wd_reg, wd_next;
    logic [dw-1:0]     rdat_reg, rdat_next;
    logic              rdat_valid_reg, rdat_valid_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;

    logic active;
    logic stb;
    logic ack;
    logic last_beat;
    logic wd_hit;
    logic wdat_take;

    // Reads present every beat back to back; writes only while a data word is held.
    assign active    = (state_reg == ACTIVE);
    assign stb       = active & (we_reg ? full_reg : 1'b1);
    assign ack       = stb & wb_ack_i;
    assign last_beat = (acked_reg == (beats_reg - 4'd1));
    assign wd_hit    = stb & ~wb_ack_i & (wd_reg == WD_LAST);

    assign cmd_ready_o  = ~active & ~wb_rst_i;
    assign wdat_ready_o = active & we_reg & (fed_reg < beats_reg) & (~full_reg | ack);
    assign wdat_take    = wdat_ready_o & wdat_valid_i;

    always_comb begin
        state_next      = state_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        sel_next        = sel_reg;
        beats_next      = beats_reg;
        acked_next      = acked_reg;
        fed_next        = fed_reg;
        full_next       = full_reg;
        wbuf_next       = wbuf_reg;
        wd_next         = wd_reg;
        rdat_next       = rdat_reg;
        rdat_valid_next = 1'b0;
        done_next       = 1'b0;
        err_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_next = ACTIVE;
                    we_next    = cmd_we_i;
                    addr_next  = cmd_addr_i;
                    sel_next   = cmd_sel_i;
                    beats_next = {1'b0, cmd_len_i} + 4'd1;
                    acked_next = 4'd0;
                    fed_next   = 4'd0;
                    full_next  = 1'b0;
                    wd_next    = 8'd0;
                end
            end

            ACTIVE: begin
                // A load in the same cycle as a drain keeps the register full.
                if (wdat_take) begin
                    wbuf_next = wdat_i;
                    fed_next  = fed_reg + 4'd1;
                    full_next = 1'b1;
                end else if (ack) begin
                    full_next = 1'b0;
                end

                if (ack) begin
                    acked_next = acked_reg + 4'd1;
                    addr_next  = addr_reg + ADDR_STEP;
                    wd_next    = 8'd0;
                    if (!we_reg) begin
                        rdat_next       = wb_dat_i;
                        rdat_valid_next = 1'b1;
                    end
                    if (last_beat) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end else if (stb) begin
                    // Starved write cycles have stb low and so never reach here.
                    wd_next = wd_reg + 8'd1;
                    if (wd_hit) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                        err_next   = 1'b1;
                        full_next  = 1'b0;
                        wbuf_next  = '0;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg      <= IDLE;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            sel_reg        <= '0;
            beats_reg      <= 4'd0;
            acked_reg      <= 4'd0;
            fed_reg        <= 4'd0;
            full_reg       <= 1'b0;
            wbuf_reg       <= '0;
            wd_reg         <= 8'd0;
            rdat_reg       <= '0;
            rdat_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            sel_reg        <= sel_next;
            beats_reg      <= beats_next;
            acked_reg      <= acked_next;
            fed_reg        <= fed_next;
            full_reg       <= full_next;
            wbuf_reg       <= wbuf_next;
            wd_reg         <= wd_next;
            rdat_reg       <= rdat_next;
            rdat_valid_reg <= rdat_valid_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        wb_cti_o = CTI_CLASSIC;
        if (active && (beats_reg != 4'd1)) begin
            wb_cti_o = last_beat ? CTI_END : CTI_INCR;
        end
    end

    assign wb_cyc_o     = active;
    assign wb_stb_o     = stb;
    assign wb_we_o      = active & we_reg;
    assign wb_addr_o    = addr_reg;
    assign wb_dat_o     = wbuf_reg;
    assign wb_sel_o     = sel_reg;
    assign rdat_o       = rdat_reg;
    assign rdat_valid_o = rdat_valid_reg;
    assign done_o       = done_reg;
    assign err_o        = err_reg;

endmodule

// File: doc/sdrc_wb_master.md
# sdrc_wb_master

Synthesizable Wishbone B3 initiator that turns simple command/data streams into single or incrementing-burst bus cycles toward the SDRAM controller's Wishbone slave port (`wb_*_i` side of `sdrc_top`). It is the initiator end of the bus the controller responds on. It lets on-chip logic, and the self-checking bench, issue reads and writes without hand-driving `stb`/`cyc`/`cti`. One transaction is in flight at a time; a watchdog aborts cycles the slave never acknowledges.

## Interface
- `APP_AW`, 26, Wishbone byte-address width
- `dw`, 32, Wishbone data width; `dw/8` byte lanes
- `TIMEOUT`, 255, max consecutive stalled cycles (`stb=1`, `ack=0`) before abort; 8-bit counter
- `wb_clk_i` in 1: single clock, all logic rising-edge
- `wb_rst_i` in 1: reset, synchronous, active-high
- `cmd_valid_i` in 1 / `cmd_ready_o` out 1: command handshake
- `cmd_we_i` in 1: 1 = write, 0 = read
- `cmd_addr_i` in APP_AW: start byte address
- `cmd_len_i` in 3: beats minus 1 (1..8 beats)
- `cmd_sel_i` in dw/8: byte enables, applied to every beat
- `wdat_valid_i` in 1 / `wdat_ready_o` out 1 / `wdat_i` in dw: write-data stream
- `rdat_valid_o` out 1 / `rdat_o` out dw: read-data stream, no backpressure
- `done_o` out 1: one-cycle pulse at transaction end
- `err_o` out 1: one-cycle pulse, coincident with `done_o`, on watchdog abort
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1
- `wb_addr_o` out APP_AW; `wb_dat_o` out dw; `wb_sel_o` out dw/8; `wb_cti_o` out 3
- `wb_ack_i` in 1; `wb_dat_i` in dw

## Operation
- States: IDLE, ACTIVE.
- IDLE: `cmd_ready_o = 1`, except while `wb_rst_i` is high, when it is 0.
- Command accept (`cmd_valid_i & cmd_ready_o`):
  - Latch all command fields.
  - `beats = cmd_len_i + 1`.
  - Go to ACTIVE.
  - `wb_cyc_o`, `wb_we_o`, `wb_sel_o` and `wb_addr_o = cmd_addr_i` are registered and valid the next cycle.
- `wb_cti_o` encoding:
  - Single beat: 3'b000.
  - Burst: 3'b010 on every beat except the last, 3'b111 on the last.
- Address rules:
  - After each acked beat, `wb_addr_o += dw/8`.
  - The address wraps modulo 2^APP_AW.
- Read:
  - `wb_stb_o` stays high for the whole burst.
  - Each ack registers `wb_dat_i` to `rdat_o` with a `rdat_valid_o` pulse.
- Write:
  - One-entry holding register drives `wb_dat_o`; `wb_stb_o` = register full.
  - `wdat_ready_o = ACTIVE & we & (fed < beats) & (!full | (stb & ack))`.
  - Load and drain in the same cycle keeps `stb` high with the new data.
  - Starvation (empty register) drops `stb` while `cyc` stays high. Stalled-by-starvation cycles are not counted by the watchdog.
- `wb_ack_i` is ignored while `stb=0` or while in IDLE.
- Completion (last-beat ack):
  - Next cycle: `cyc`/`stb`/`we`/`cti` go to 0, `done_o` pulses, state is IDLE.
- Watchdog:
  - Counts cycles with `stb & !ack`; resets on ack.
  - On reaching `TIMEOUT`, next cycle: `cyc`/`stb` go to 0, `done_o` and `err_o` pulse, holding register is cleared, remaining read beats are never presented.
- Reset mid-transaction: the transaction is dropped, with no `done_o` and no `err_o`.
- Reset values, all outputs: 0, with `cti` = 3'b000.

## Timing
- Cmd accepted at cycle N:
  - Read: `cyc`/`stb` high at N+1; the fastest slave acks at N+1.
  - Write: `wdat_ready_o` can be high from N+1; `stb` rises the cycle after the first data beat is accepted.
- Ack at cycle M:
  - Read data appears on `rdat_o` at M+1.
  - The next beat's address is on the bus at M+1.
- Last ack at L:
  - `done_o` at L+1; IDLE and `cmd_ready_o = 1` at L+1.
  - The next command can be accepted at L+1 and drives `cyc` at L+2, giving at least one idle bus cycle between transactions.
- Zero-wait-state burst of B beats: `cyc` is high exactly B cycles for reads.

## Test plan
- Single read:
  - Stimulus: addr 0x0000100, len 0, slave acks 2 cycles after `stb` with 0xDEADBEEF.
  - Required: `cti` = 000; one `rdat_valid_o` with 0xDEADBEEF at ack+1; `done_o` at ack+1; `cyc` high 3 cycles.
- 8-beat write burst, data always valid, slave acks every cycle:
  - Addresses 0x100, 0x104 … 0x11C.
  - `cti` = 010 ×7 then 111.
  - `wb_dat_o` follows input order.
  - `wdat_ready_o` deasserts after 8 accepts.
- 4-beat write, data gaps:
  - Stimulus: `wdat_valid_i` low for 3 cycles before beat 3.
  - Required: `stb` low during the gap, `cyc` held high; no `err_o` even with `TIMEOUT=2`.
- Address wrap:
  - Stimulus: 4-beat read at 0x3FFFFF8 (APP_AW=26).
  - Required: addresses 0x3FFFFF8, 0x3FFFFFC, 0x0000000, 0x0000004.
- Timeout:
  - Stimulus: `TIMEOUT=16`, slave never acks a 4-beat read.
  - Required: `cyc` drops after 16 stalled cycles; `done_o` and `err_o` pulse together; zero `rdat_valid_o`; next command accepted.
- Reset mid-burst:
  - Stimulus: `wb_rst_i` high for 1 cycle after beat 2 of 8.
  - Required: next cycle all outputs at reset values; no `done_o`; `cmd_ready_o` high the cycle after reset deasserts.
